// File: rtl/modport_rr_arbiter_if.sv
// Valid/ready beat bundle shared by the arbiter's upstream and downstream sides.
// NUM_CH lanes are carried side by side; the downstream side uses NUM_CH=1.
interface modport_rr_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH*WIDTH-1:0] data;
  logic [NUM_CH-1:0]       last;
  logic [NUM_CH-1:0]       ready;

  // Producer drives the beat, consumer answers with ready.
  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/modport_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with packet locking and a 2-entry
// registered output buffer, so upstream ready never sees downstream ready.
module modport_rr_arbiter #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  modport_rr_arbiter_if.slave  up,
  modport_rr_arbiter_if.master dn,
  output logic [CH_W-1:0]      o_ch,
  output logic                 o_busy
);

  logic [1:0]       r_count;
  logic [CH_W-1:0]  r_rrPtr;
  logic [CH_W-1:0]  r_lockCh;
  logic             r_locked;
  logic [WIDTH-1:0] r_data [2];
  logic             r_last [2];
  logic [CH_W-1:0]  r_ch   [2];

  logic [WIDTH-1:0] w_chData [NUM_CH];
  logic [CH_W-1:0]  w_grant;
  logic [CH_W-1:0]  w_idx;
  logic             w_grantValid;
  logic             w_room;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_inData;
  logic             w_inLast;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign w_chData[g] = up.data[g*WIDTH +: WIDTH];
  end

  // Pick the locked channel, otherwise the first valid channel from the pointer on.
  always_comb begin
    w_grant      = '0;
    w_grantValid = 1'b0;
    w_idx        = '0;
    if (r_locked) begin
      w_grant      = r_lockCh;
      w_grantValid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        w_idx = CH_W'((int'(r_rrPtr) + i) % NUM_CH);
        if (!w_grantValid && up.valid[w_idx]) begin
          w_grant      = w_idx;
          w_grantValid = 1'b1;
        end
      end
    end
  end

  assign w_room   = (r_count != 2'd2);
  assign w_inData = w_chData[w_grant];
  assign w_inLast = up.last[w_grant];
  assign w_push   = w_grantValid && w_room && up.valid[w_grant];
  assign w_pop    = dn.valid[0] && dn.ready[0];

  // Only the granted channel sees ready, and only while the buffer has room.
  always_comb begin
    up.ready = '0;
    if (!i_rst && w_grantValid && w_room) begin
      up.ready[w_grant] = 1'b1;
    end
  end

  // Packet lock and round-robin pointer advance on each accepted beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_locked <= 1'b0;
      r_lockCh <= '0;
      r_rrPtr  <= '0;
    end else if (w_push) begin
      if (w_inLast) begin
        r_locked <= 1'b0;
        r_rrPtr  <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);
      end else begin
        r_locked <= 1'b1;
        r_lockCh <= w_grant;
      end
    end
  end

  // Two-entry FIFO with entry 0 as head; entries shift forward on pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= 2'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
      r_ch[0]   <= '0;
      r_ch[1]   <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data[0] <= w_inData;
            r_last[0] <= w_inLast;
            r_ch[0]   <= w_grant;
          end else begin
            r_data[1] <= w_inData;
            r_last[1] <= w_inLast;
            r_ch[1]   <= w_grant;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data[0] <= r_data[1];
          r_last[0] <= r_last[1];
          r_ch[0]   <= r_ch[1];
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_data[0] <= w_inData;
            r_last[0] <= w_inLast;
            r_ch[0]   <= w_grant;
          end else begin
            r_data[0] <= r_data[1];
            r_last[0] <= r_last[1];
            r_ch[0]   <= r_ch[1];
            r_data[1] <= w_inData;
            r_last[1] <= w_inLast;
            r_ch[1]   <= w_grant;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dn.valid[0] = (r_count != 2'd0);
  assign dn.data     = r_data[0];
  assign dn.last[0]  = r_last[0];
  assign o_ch        = r_ch[0];
  assign o_busy      = r_locked | (r_count != 2'd0);

endmodule

// File: tb/tb_modport_rr_arbiter.sv
// Self-checking bench for modport_rr_arbiter: directed scenarios plus random
// traffic, compared each cycle against a queue-based behavioural model.
module tb_modport_rr_arbiter;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 2;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    int               ch;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            iReady;
  logic [CH_W-1:0] oCh;
  logic            oBusy;

  beat_t srcQ [NUM_CH][$];
  beat_t modelQ [$];
  beat_t outLog [$];
  logic [NUM_CH-1:0] hold;
  int rrPtr;
  int lockCh;
  int tests;
  int failed;

  modport_rr_arbiter_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) upIf ();
  modport_rr_arbiter_if #(.NUM_CH(1), .WIDTH(WIDTH)) dnIf ();

  modport_rr_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .up     (upIf),
    .dn     (dnIf),
    .o_ch   (oCh),
    .o_busy (oBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant(input logic [NUM_CH-1:0] vld);
    if (lockCh >= 0) return lockCh;
    for (int i = 0; i < NUM_CH; i++) begin
      if (vld[(rrPtr + i) % NUM_CH]) return (rrPtr + i) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic bit allEmpty();
    for (int k = 0; k < NUM_CH; k++) begin
      if (srcQ[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    rrPtr  = 0;
    lockCh = -1;
    hold   = '0;
    for (int k = 0; k < NUM_CH; k++) srcQ[k].delete();
  endtask

  // One clock cycle: drive sources, compare DUT against model, advance model.
  task automatic applyStimulus();
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] expReady;
    int g;
    bit pushed;
    beat_t b;
    @(negedge clk);
    vld = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (srcQ[k].size() > 0) begin
        vld[k] = !hold[k];
        upIf.data[k*WIDTH +: WIDTH] = srcQ[k][0].d;
        upIf.last[k] = srcQ[k][0].l;
      end else begin
        upIf.data[k*WIDTH +: WIDTH] = '0;
        upIf.last[k] = 1'b0;
      end
    end
    upIf.valid = vld;
    dnIf.ready[0] = iReady;
    #1;
    g = modelGrant(vld);
    expReady = '0;
    if (g >= 0 && modelQ.size() < 2) expReady[g] = 1'b1;
    checkOutput("o_ready", upIf.ready, expReady);
    checkOutput("o_valid", dnIf.valid[0], modelQ.size() != 0);
    checkOutput("o_busy", oBusy, (lockCh >= 0) || (modelQ.size() != 0));
    if (modelQ.size() != 0) begin
      checkOutput("o_data", dnIf.data, modelQ[0].d);
      checkOutput("o_last", dnIf.last[0], modelQ[0].l);
      checkOutput("o_ch", oCh, modelQ[0].ch);
    end
    if (dnIf.valid[0] && iReady) outLog.push_back('{dnIf.data, dnIf.last[0], int'(oCh)});
    pushed = (expReady != '0) && vld[g];
    if (modelQ.size() != 0 && iReady) void'(modelQ.pop_front());
    if (pushed) begin
      b = srcQ[g].pop_front();
      b.ch = g;
      modelQ.push_back(b);
      if (b.l) begin
        lockCh = -1;
        rrPtr  = (g + 1) % NUM_CH;
      end else begin
        lockCh = g;
      end
    end
  endtask

  task automatic runUntilDrained(input int budget, input string tag);
    int n = 0;
    while (!(allEmpty() && modelQ.size() == 0 && lockCh < 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, (allEmpty() && modelQ.size() == 0 && lockCh < 0), 1);
  endtask

  task automatic checkLog(input string tag, input int idx, input int ch, input logic [WIDTH-1:0] d);
    if (idx < outLog.size()) begin
      checkOutput({tag, "_ch"}, outLog[idx].ch, ch);
      checkOutput({tag, "_data"}, outLog[idx].d, d);
    end else begin
      checkOutput({tag, "_present"}, outLog.size(), idx + 1);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    iReady = 1'b1;
    upIf.valid = '0;
    upIf.data = '0;
    upIf.last = '0;
    dnIf.ready = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_valid", dnIf.valid[0], 0);
    checkOutput("rst_data", dnIf.data, 0);
    checkOutput("rst_last", dnIf.last[0], 0);
    checkOutput("rst_ch", oCh, 0);
    checkOutput("rst_busy", oBusy, 0);
    checkOutput("rst_ready", upIf.ready, 0);
    repeat (3) applyStimulus();

    // Pure round-robin with single-beat packets.
    outLog.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_CH; k++) srcQ[k].push_back('{8'h10 + 8'(k), 1'b1, 0});
    runUntilDrained(40, "rr_drain");
    checkOutput("rr_count", outLog.size(), 8);
    for (int i = 0; i < 8; i++) checkLog("rr", i, i % NUM_CH, 8'h10 + 8'(i % NUM_CH));

    // Locked 3-beat packet on channel 1 with a 2-cycle bubble; channel 2 waits.
    outLog.delete();
    srcQ[1].push_back('{8'hA1, 1'b0, 0});
    srcQ[1].push_back('{8'hA2, 1'b0, 0});
    srcQ[1].push_back('{8'hA3, 1'b1, 0});
    srcQ[2].push_back('{8'h20, 1'b1, 0});
    repeat (2) applyStimulus();
    hold[1] = 1'b1;
    repeat (2) begin
      applyStimulus();
      checkOutput("lock_no_ch2", upIf.ready[2], 0);
    end
    hold[1] = 1'b0;
    runUntilDrained(40, "lock_drain");
    checkLog("lock0", 0, 1, 8'hA1);
    checkLog("lock1", 1, 1, 8'hA2);
    checkLog("lock2", 2, 1, 8'hA3);
    checkLog("lock3", 3, 2, 8'h20);

    // Back-pressure: buffer fills to two beats and holds its head.
    outLog.delete();
    iReady = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_CH; k++) srcQ[k].push_back('{8'h30 + 8'(k), 1'b1, 0});
    repeat (5) applyStimulus();
    checkOutput("bp_ready", upIf.ready, 0);
    checkOutput("bp_head", dnIf.data, 8'h33);
    iReady = 1'b1;
    runUntilDrained(60, "bp_drain");
    checkLog("bp0", 0, 3, 8'h33);
    checkLog("bp1", 1, 0, 8'h30);
    checkLog("bp2", 2, 1, 8'h31);

    // Pointer wrap from channel 3 back to channel 0.
    srcQ[3].push_back('{8'h43, 1'b1, 0});
    runUntilDrained(20, "wrap_pre");
    outLog.delete();
    srcQ[0].push_back('{8'h50, 1'b1, 0});
    srcQ[3].push_back('{8'h53, 1'b1, 0});
    runUntilDrained(20, "wrap_drain");
    checkLog("wrap0", 0, 0, 8'h50);
    checkLog("wrap1", 1, 3, 8'h53);

    // Asynchronous reset while locked on channel 2 with a full buffer.
    srcQ[1].push_back('{8'h61, 1'b1, 0});
    runUntilDrained(20, "prelock_drain");
    iReady = 1'b0;
    for (int r = 0; r < 3; r++) srcQ[2].push_back('{8'h70 + 8'(r), 1'b0, 0});
    repeat (3) applyStimulus();
    checkOutput("full_busy", oBusy, 1);
    checkOutput("full_ready", upIf.ready, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_valid", dnIf.valid[0], 0);
    checkOutput("async_busy", oBusy, 0);
    checkOutput("async_ready", upIf.ready, 0);
    upIf.valid = '0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_busy", oBusy, 0);
    checkOutput("post_rst_valid", dnIf.valid[0], 0);
    iReady = 1'b1;
    outLog.delete();
    srcQ[0].push_back('{8'h80, 1'b1, 0});
    srcQ[1].push_back('{8'h81, 1'b1, 0});
    srcQ[3].push_back('{8'h83, 1'b1, 0});
    runUntilDrained(20, "post_rst_drain");
    checkLog("post_rst0", 0, 0, 8'h80);

    // Random traffic with random packet lengths, bubbles and back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (srcQ[k].size() < 3 && $urandom_range(0, 2) == 0)
          srcQ[k].push_back('{8'($urandom), ($urandom_range(0, 2) == 0), 0});
        hold[k] = ($urandom_range(0, 9) == 0);
      end
      iReady = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    hold = '0;
    iReady = 1'b1;
    for (int k = 0; k < NUM_CH; k++) srcQ[k].push_back('{8'hEE, 1'b1, 0});
    runUntilDrained(300, "rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/modport_rr_arbiter.md
Name: modport_rr_arbiter

Overview:
- N-channel valid/ready arbiter. Merges NUM_CH upstream producer channels into one downstream consumer channel.
- Round-robin fairness with packet locking: a multi-beat packet is never interleaved with another channel's beats.
- Output stage is a 2-entry registered buffer, so upstream ready never depends combinationally on downstream ready.
- Sits between master-side bus ports and a shared slave-side port in interface-based fabrics.

Parameters:
- NUM_CH, 4, number of upstream channels (>=2).
- WIDTH, 8, payload bits per beat.
- CH_W, $clog2(NUM_CH), width of the channel-index field (derived; never overridden).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  NUM_CH  per-channel beat valid.
- i_data  input  NUM_CH*WIDTH  per-channel payload; channel k occupies bits [k*WIDTH +: WIDTH].
- i_last  input  NUM_CH  per-channel end-of-packet flag.
- o_ready  output  NUM_CH  per-channel accept.
- o_valid  output  1  downstream beat valid.
- i_ready  input  1  downstream accept.
- o_data  output  WIDTH  downstream payload.
- o_last  output  1  downstream end-of-packet.
- o_ch  output  CH_W  source channel of the current o_data.
- o_busy  output  1  high while a packet is locked or the buffer is non-empty.

Behaviour:
- Reset (async, i_rst=1):
  - count=0, rr_ptr=0, locked=0, lock_ch=0.
  - o_valid=0, o_data=0, o_last=0, o_ch=0, o_busy=0.
  - o_ready forced all-0 while i_rst is high.
- Reset mid-packet discards the lock, the pointer and all buffered beats. No partial beat is emitted after release.
- Grant, combinational:
  - If locked: grant=lock_ch.
  - Else: grant is the first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, … mod NUM_CH.
  - If not locked and no channel is valid: no grant.
- Ready: o_ready[k]=1 iff k==grant and count<2. At most one bit is high. o_ready depends on registered count only, never on i_ready.
- Push: i_valid[grant] && o_ready[grant]. Writes {i_data slice, i_last[grant], grant} into the buffer tail.
- Pop: o_valid && i_ready.
- Lock/pointer update on a push:
  - i_last=0: locked<=1, lock_ch<=grant.
  - i_last=1: locked<=0, rr_ptr<=(grant+1) mod NUM_CH. Wrap from NUM_CH-1 to 0.
  - While locked, other channels' valids are ignored, even if the locked channel deasserts valid (a bubble is permitted; the lock is held).
- Buffer:
  - 2 entries; count in 0..2. o_valid=(count!=0). o_data/o_last/o_ch present the head entry.
  - Latency: a beat accepted in cycle t is visible on o_* in cycle t+1 when the buffer was empty.
  - Simultaneous push and pop: count unchanged, order preserved.
  - count=2: no push possible (o_ready=0). A pop alone drops count to 1; o_ready re-asserts the next cycle.
  - count=0 with a pop: impossible by construction, since o_valid=0.
- Stability: while o_valid=1 and i_ready=0, o_data, o_last and o_ch hold constant.
- o_busy = locked | (count!=0).
- Single-beat packets (i_last=1 on every beat) give pure round-robin, one beat per channel per turn.

Test Plan:
- Reset, then idle → all outputs 0. Assert i_rst asynchronously mid-cycle → o_valid drops without a clock edge.
- NUM_CH=4. Channels 0..3 each hold single-beat data 0x10+k, i_ready=1 → o_data sequence 0x10,0x11,0x12,0x13,0x10…, o_ch 0,1,2,3,0; one beat per cycle after 1-cycle latency.
- Channel 1 sends a 3-beat packet (A1,A2,A3 with last on A3) while channel 2 is valid throughout → output A1,A2,A3 then channel-2 beat. Channel 1 drops valid for 2 cycles mid-packet → output bubbles, channel 2 is not granted.
- i_ready=0 for 5 cycles with all channels valid → exactly 2 beats accepted (count=2), o_ready all 0, o_data stable. Raise i_ready → beats drain in acceptance order and the third beat is accepted the cycle after the first pop.
- rr_ptr wrap: last packet from channel 3, only channels 0 and 3 valid → next grant is channel 0, then 3.
- Reset asserted while locked on channel 2 with count=2 → after release o_busy=0, o_valid=0, and the first grant search starts at channel 0.
